// File: rtl/pearson_pkg.sv
// Shared definitions for the Pearson hash engine: permutation table function,
// its constants and the message FSM state encoding.
package pearson_pkg;

  localparam logic [7:0] PEARSON_MUL = 8'd167;
  localparam logic [7:0] PEARSON_ADD = 8'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // T[x] = (167*x + 13) mod 256; 8-bit arithmetic supplies the modulo.
  function automatic logic [7:0] pearson_t(input logic [7:0] x);
    logic [7:0] r;
    r = x * PEARSON_MUL + PEARSON_ADD;
    return r;
  endfunction

endpackage

// File: rtl/pearson_lane.sv
// One 8-bit Pearson hash lane: running hash register plus the first-byte /
// chained lookup that produces its next value.
module pearson_lane
  import pearson_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       first_i,
  input  logic [7:0] data_i,
  output logic [7:0] hash_next_o
);

  localparam logic [7:0] LANE_OFFS = 8'(LANE_IDX);

  logic [7:0] hash_q;
  logic [7:0] lookup_idx;

  // The first byte is seeded with the lane index so lanes diverge.
  assign lookup_idx  = first_i ? (data_i + LANE_OFFS) : (hash_q ^ data_i);
  assign hash_next_o = pearson_t(lookup_idx);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hash_q <= 8'h00;
    end else if (load_i) begin
      hash_q <= hash_next_o;
    end
  end

endmodule

// File: rtl/pearson_hash_stream.sv
// Streaming multi-lane Pearson hash: accepts framed bytes over valid/ready and
// presents the hash and saturating length over a second valid/ready port.
module pearson_hash_stream
  import pearson_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               msg_valid_i,
  input  logic [7:0]         msg_data_i,
  input  logic               msg_last_i,
  output logic               msg_ready_o,
  output logic               hash_valid_o,
  input  logic               hash_ready_i,
  output logic [8*LANES-1:0] hash_o,
  output logic [CNT_W-1:0]   len_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid must not depend on ready, and data is held until taken.

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic               accept;
  logic               first_byte;
  logic [8*LANES-1:0] lane_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8*LANES-1:0] hash_q;
  logic [CNT_W-1:0]   len_q;

  assign accept     = msg_valid_i && msg_ready_o;
  assign first_byte = (state_q == IDLE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pearson_lane #(.LANE_IDX(i)) u_lane (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (accept),
      .first_i    (first_byte),
      .data_i     (msg_data_i),
      .hash_next_o(lane_next[8*i +: 8])
    );
  end

  always_comb begin
    state_d      = state_q;
    msg_ready_o  = 1'b1;
    hash_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = msg_last_i ? DONE : ACCUM;
      end
      ACCUM: begin
        busy_o = 1'b1;
        if (accept && msg_last_i) state_d = DONE;
      end
      DONE: begin
        msg_ready_o  = 1'b0;
        hash_valid_o = 1'b1;
        if (hash_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Running length restarts at 1 on a message's first byte and sticks at max.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      if (first_byte)            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hash_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Results only move on the last byte, so partial hashes never surface.
      if (accept && msg_last_i) begin
        hash_q <= lane_next;
        len_q  <= cnt_d;
      end
    end
  end

  assign hash_o      = hash_q;
  assign len_o       = len_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pearson_hash_stream.sv
// Directed and randomized checks of pearson_hash_stream against a message-level
// Pearson reference model (LANES=2, CNT_W=4 so length saturation is reachable).
module tb_pearson_hash_stream;

  localparam int LANES = 2;
  localparam int CNT_W = 4;
  localparam int LEN_MAX = (1 << CNT_W) - 1;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               msg_valid_i;
  logic [7:0]         msg_data_i;
  logic               msg_last_i;
  logic               msg_ready_o;
  logic               hash_valid_o;
  logic               hash_ready_i;
  logic [8*LANES-1:0] hash_o;
  logic [CNT_W-1:0]   len_o;
  logic               busy_o;
  logic [1:0]         dbg_state_o;

  int n_pass = 0;
  int n_checks = 0;

  pearson_hash_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .msg_valid_i (msg_valid_i),
    .msg_data_i  (msg_data_i),
    .msg_last_i  (msg_last_i),
    .msg_ready_o (msg_ready_o),
    .hash_valid_o(hash_valid_o),
    .hash_ready_i(hash_ready_i),
    .hash_o      (hash_o),
    .len_o       (len_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock/reset
  always #5 clk_i = ~clk_i;

  // Reference model
  function automatic int t_ref(input int x);
    return (167 * x + 13) % 256;
  endfunction

  function automatic logic [8*LANES-1:0] model_hash(input logic [7:0] m[$]);
    logic [8*LANES-1:0] r;
    r = '0;
    for (int ln = 0; ln < LANES; ln++) begin
      int h;
      h = t_ref((int'(m[0]) + ln) % 256);
      for (int k = 1; k < m.size(); k++) h = t_ref(h ^ int'(m[k]));
      r[8*ln +: 8] = 8'(h);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] model_len(input int n);
    return CNT_W'((n > LEN_MAX) ? LEN_MAX : n);
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Driver: present a byte and hold it until the edge that accepts it.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    msg_last_i  = last;
    t = 0;
    while (!msg_ready_o && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("accept_timeout", 32'(t), 32'(0));
    tick();
  endtask

  logic [7:0]         msg[$];
  logic [8*LANES-1:0] hold_hash;
  logic [CNT_W-1:0]   hold_len;

  initial begin
    reset_i      = 1'b1;
    msg_valid_i  = 1'b0;
    msg_data_i   = 8'h00;
    msg_last_i   = 1'b0;
    hash_ready_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();

    // Reset state
    check("rst_hash_valid", 32'(hash_valid_o), 32'(0));
    check("rst_hash", 32'(hash_o), 32'(0));
    check("rst_len", 32'(len_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_ready", 32'(msg_ready_o), 32'(1));
    check("rst_state", 32'(dbg_state_o), 32'(pearson_pkg::IDLE));

    // Single byte 0x00
    send_byte(8'h00, 1'b1);
    msg_valid_i = 1'b0;
    check("one_valid", 32'(hash_valid_o), 32'(1));
    check("one_hash", 32'(hash_o), 32'h0000B40D);
    check("one_len", 32'(len_o), 32'(1));
    check("one_ready", 32'(msg_ready_o), 32'(0));
    hash_ready_i = 1'b1;
    tick();
    hash_ready_i = 1'b0;
    check("one_release_ready", 32'(msg_ready_o), 32'(1));
    check("one_release_valid", 32'(hash_valid_o), 32'(0));

    // Two bytes with a 3-cycle bubble
    send_byte(8'h00, 1'b0);
    msg_valid_i = 1'b0;
    check("bub_busy0", 32'(busy_o), 32'(1));
    for (int b = 0; b < 3; b++) begin
      tick();
      check("bub_busy", 32'(busy_o), 32'(1));
      check("bub_no_valid", 32'(hash_valid_o), 32'(0));
    end
    send_byte(8'h01, 1'b1);
    check("bub_hash", 32'(hash_o), 32'h000020E1);
    check("bub_len", 32'(len_o), 32'(2));
    check("bub_busy_done", 32'(busy_o), 32'(0));

    // Backpressure; a waiting byte must not be taken while the result is held
    msg_valid_i = 1'b1;
    msg_data_i  = 8'hFF;
    msg_last_i  = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick();
      check("bp_valid", 32'(hash_valid_o), 32'(1));
      check("bp_ready", 32'(msg_ready_o), 32'(0));
      check("bp_hash", 32'(hash_o), 32'h000020E1);
      check("bp_len", 32'(len_o), 32'(2));
    end
    hash_ready_i = 1'b1;
    tick();
    hash_ready_i = 1'b0;
    msg_valid_i  = 1'b0;
    check("bp_release_ready", 32'(msg_ready_o), 32'(1));
    check("bp_release_valid", 32'(hash_valid_o), 32'(0));
    check("bp_release_busy", 32'(busy_o), 32'(0));
    check("bp_release_len", 32'(len_o), 32'(2));

    // 20-byte message: length saturates at 15, hash covers every byte
    msg.delete();
    for (int k = 0; k < 20; k++) msg.push_back(8'($urandom_range(0, 255)));
    for (int k = 0; k < 20; k++) send_byte(msg[k], k == 19);
    msg_valid_i = 1'b0;
    check("sat_valid", 32'(hash_valid_o), 32'(1));
    check("sat_len", 32'(len_o), 32'(model_len(20)));
    check("sat_hash", 32'(hash_o), 32'(model_hash(msg)));
    hold_hash = hash_o;
    hold_len  = len_o;
    hash_ready_i = 1'b1;
    tick();
    hash_ready_i = 1'b0;

    // Reset mid-message aborts it
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    check("mid_busy", 32'(busy_o), 32'(1));
    check("mid_result_kept", 32'(hash_o), 32'(hold_hash));
    msg_valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_busy", 32'(busy_o), 32'(0));
    check("arst_hash", 32'(hash_o), 32'(0));
    check("arst_len", 32'(len_o), 32'(0));
    check("arst_ready", 32'(msg_ready_o), 32'(1));
    check("arst_valid", 32'(hash_valid_o), 32'(0));
    tick();
    reset_i = 1'b0;
    tick();
    check("post_rst_valid", 32'(hash_valid_o), 32'(0));
    send_byte(8'h00, 1'b1);
    msg_valid_i = 1'b0;
    check("post_rst_hash", 32'(hash_o), 32'h0000B40D);
    check("post_rst_len", 32'(len_o), 32'(1));
    hash_ready_i = 1'b1;
    tick();

    // Back-to-back random messages, hash_ready tied high, valid continuous
    for (int m = 0; m < 12; m++) begin
      int n;
      n = $urandom_range(1, 20);
      msg.delete();
      for (int k = 0; k < n; k++) msg.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < n; k++) send_byte(msg[k], k == n - 1);
      check("b2b_valid", 32'(hash_valid_o), 32'(1));
      check("b2b_hash", 32'(hash_o), 32'(model_hash(msg)));
      check("b2b_len", 32'(len_o), 32'(model_len(n)));
      msg_data_i = 8'($urandom_range(0, 255));
      msg_last_i = 1'b0;
      tick();
      check("b2b_one_done", 32'(hash_valid_o), 32'(0));
      check("b2b_ready", 32'(msg_ready_o), 32'(1));
    end
    msg_valid_i  = 1'b0;
    hash_ready_i = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pearson_hash_stream.md
# pearson_hash_stream

Streaming, parametrised Pearson hash engine that consumes a byte-wide message over a valid/ready handshake and produces a multi-lane (8·LANES-bit) hash plus message length. It succeeds the fixed 8-byte, free-running hash datapath. This engine accepts arbitrary-length messages with explicit framing and backpressure. It computes all lanes in parallel at one byte per cycle. It sits between a byte-stream source (UART/FIFO) and any consumer needing a fingerprint.

## Interface
- LANES, 2, number of independent 8-bit hash lanes; hash width is 8·LANES, legal range 1..8
- CNT_W, 16, width of the message-length counter
- clk_i  in  1  clock, rising-edge
- reset_i  in  1  reset, asynchronous, active-high
- msg_valid_i  in  1  msg_data_i/msg_last_i valid
- msg_data_i  in  8  message byte
- msg_last_i  in  1  marks final byte of message
- msg_ready_o  out  1  engine accepts a byte this cycle
- hash_valid_o  out  1  hash_o/len_o hold a completed result
- hash_ready_i  in  1  consumer takes result
- hash_o  out  8·LANES  result; lane i occupies bits [8i+7:8i]
- len_o  out  CNT_W  byte count of hashed message, saturating
- busy_o  out  1  message in progress (at least one byte accepted, last not yet accepted)

## Operation
- Table T: fixed permutation T[x] = (167·x + 13) mod 256, from the shared package.
- Per lane i, for message bytes c0..cN-1:
  - first byte: h_i := T[(c0 + i) mod 256];
  - each later byte c: h_i := T[h_i xor c].
- A byte is accepted on a rising edge with msg_valid_i && msg_ready_o. Empty messages do not exist: msg_last_i on the first byte gives a 1-byte message.
- FSM states:
  - IDLE: msg_ready_o=1, busy_o=0. Accepted byte with last=0 goes to ACCUM. Accepted byte with last=1 goes to DONE.
  - ACCUM: msg_ready_o=1, busy_o=1. Accepted byte with last=1 goes to DONE. Otherwise the FSM stays in ACCUM, and msg_valid_i bubbles are ignored.
  - DONE: msg_ready_o=0, hash_valid_o=1. hash_valid_o && hash_ready_i returns to IDLE.
- len_o: cleared on the first byte, then incremented per accepted byte. It saturates at 2^CNT_W−1 and never wraps. Hash computation continues past saturation.
- hash_o and len_o are registered and stable for the whole DONE state. They keep their last result in IDLE/ACCUM until overwritten; consumers qualify with hash_valid_o.
- Reset (any state, including mid-message) aborts the message. No partial result is ever presented.

## Timing
- Reset values: hash_valid_o=0, hash_o=0, len_o=0, busy_o=0, msg_ready_o=1 (IDLE).
- Throughput: one byte per cycle per message. An N-byte message occupies N accept cycles, plus at least one DONE cycle.
- Latency: the last byte is accepted at edge k; hash_valid_o=1 with the final hash in the cycle after edge k.
- DONE handshake at edge m: msg_ready_o=1 in the cycle after edge m. No message byte is accepted while hash_valid_o=1.
- hash_ready_i may be held high permanently, giving a 1-cycle DONE. hash_ready_i asserted outside DONE has no effect.
- Table lookup is combinational from the lane register and input byte. Lane registers update at the accept edge.

## Structure
- Shared package pearson_pkg holds:
  - function pearson_t(byte) returning T[x];
  - FSM state enum {IDLE, ACCUM, DONE};
  - the constants 167 and 13.
- Sub-module pearson_lane (parameter LANE_IDX) holds one 8-bit hash register and its lookup/first-byte mux. The top generates LANES instances and owns the FSM, length counter and handshake.

## Test plan
- LANES=2, one byte 0x00 with last=1 → next cycle hash_valid_o=1, hash_o=0xB40D, len_o=1.
- LANES=2, bytes 0x00,0x01 (last on second), with a 3-cycle msg_valid_i bubble between them → hash_o=0x20E1, len_o=2, busy_o=1 through the bubble.
- Backpressure: hash_ready_i held 0 for 5 cycles after completion → hash_o/len_o stable, msg_ready_o=0; release → msg_ready_o=1 on the following cycle.
- CNT_W=4, 20-byte message → len_o=15; hash_o matches the reference model over all 20 bytes.
- reset_i pulsed after 3 of 6 bytes → all outputs at reset values. A following 1-byte message 0x00 yields 0xB40D.
- Back-to-back messages with hash_ready_i tied 1 and msg_valid_i continuous → every hash matches the model, with exactly one DONE cycle between messages.
